n_bit_register: RTL and testbench

N_BIT_REGISTER -- requirements
Module: n_bit_register

---
 rtl/n_bit_register_if.sv | 12 +
 rtl/n_bit_register.sv | 52 +++++
 tb/tb_n_bit_register.sv | 122 ++++++++++++
 3 files changed

// File: rtl/n_bit_register_if.sv
// Operation/data bundle for n_bit_register: enable, function select, load data and registered output.
interface n_bit_register_if #(
  parameter int unsigned N = 8
);
  logic         E;
  logic [1:0]   FunSel;
  logic [N-1:0] I;
  logic [N-1:0] Q;

  modport master (output E, output FunSel, output I, input Q);
  modport slave  (input E, input FunSel, input I, output Q);
endinterface

// File: rtl/n_bit_register.sv
// N-bit register with decrement/increment/load/clear and synchronous active-low reset.
// Define N_BIT_REGISTER_SAT_EN to make increment/decrement saturate instead of wrapping.
module n_bit_register #(
  parameter int unsigned  N           = 8,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic           CLK,
  input  logic           RST_N,
  n_bit_register_if.slave bus
);

  localparam logic [N-1:0] ALL_ZEROS = '0;
  localparam logic [N-1:0] ALL_ONES  = '1;
  localparam logic [N-1:0] ONE       = N'(1);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] dec_val;
  logic [N-1:0] inc_val;

  // Edge values at the counting limits depend on the build's overflow policy.
  always_comb begin
    dec_val = q_q - ONE;
    inc_val = q_q + ONE;
`ifdef N_BIT_REGISTER_SAT_EN
    if (q_q == ALL_ZEROS) dec_val = ALL_ZEROS;
    if (q_q == ALL_ONES)  inc_val = ALL_ONES;
`endif
  end

  always_comb begin
    q_d = q_q;
    if (bus.E) begin
      case (bus.FunSel)
        2'b00:   q_d = dec_val;
        2'b01:   q_d = inc_val;
        2'b10:   q_d = bus.I;
        2'b11:   q_d = ALL_ZEROS;
        default: q_d = q_q;
      endcase
    end
  end

  // Reset wins over any pending operation at the same edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) q_q <= RESET_VALUE;
    else        q_q <= q_d;
  end

  assign bus.Q = q_q;

endmodule

// File: tb/tb_n_bit_register.sv
// Directed self-checking bench for n_bit_register (N=8 default instance and N=4, RESET_VALUE=9 instance).
module tb_n_bit_register;

`ifdef N_BIT_REGISTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  n_bit_register_if #(.N(8)) bus8 ();
  n_bit_register_if #(.N(4)) bus4 ();

  n_bit_register #(.N(8), .RESET_VALUE(8'h00)) u_dut8 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus8.slave)
  );

  n_bit_register #(.N(4), .RESET_VALUE(4'h9)) u_dut4 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic e, input logic [1:0] fs, input logic [7:0] i);
    bus8.E = e; bus8.FunSel = fs; bus8.I = i;
  endtask

  task automatic drive4(input logic e, input logic [1:0] fs, input logic [3:0] i);
    bus4.E = e; bus4.FunSel = fs; bus4.I = i;
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive8(1'b0, 2'b00, 8'h00);
    drive4(1'b0, 2'b00, 4'h0);
    #2;

    // Reset and initial load
    step();
    check("rst8", 64'(bus8.Q), 64'h00);
    check("rst4", 64'(bus4.Q), 64'h9);
    rst_n = 1'b1;
    drive8(1'b1, 2'b10, 8'hAA);
    step();
    check("load_aa", 64'(bus8.Q), 64'hAA);

    // Operation sweep from 0xAA
    drive8(1'b1, 2'b00, 8'h00); step(); check("dec", 64'(bus8.Q), 64'hA9);
    drive8(1'b1, 2'b01, 8'h00); step(); check("inc", 64'(bus8.Q), 64'hAA);
    drive8(1'b1, 2'b10, 8'hAA); step(); check("load", 64'(bus8.Q), 64'hAA);
    drive8(1'b1, 2'b11, 8'h5A); step(); check("clear", 64'(bus8.Q), 64'h00);

    // Hold with E=0 regardless of FunSel and I
    drive8(1'b1, 2'b10, 8'hAA); step(); check("reload", 64'(bus8.Q), 64'hAA);
    for (int k = 0; k < 4; k++) begin
      drive8(1'b0, 2'(k), 8'(8'h11 * (k + 1)));
      step();
      check($sformatf("hold_fs%0d", k), 64'(bus8.Q), 64'hAA);
    end

    // Counting limits
    drive8(1'b1, 2'b10, 8'hFF); step(); check("load_ff", 64'(bus8.Q), 64'hFF);
    drive8(1'b1, 2'b01, 8'h00); step(); check("inc_ff", 64'(bus8.Q), SAT ? 64'hFF : 64'h00);
    drive8(1'b1, 2'b11, 8'h00); step(); check("clr_00", 64'(bus8.Q), 64'h00);
    drive8(1'b1, 2'b00, 8'h00); step(); check("dec_00", 64'(bus8.Q), SAT ? 64'h00 : 64'hFF);
    drive8(1'b1, 2'b10, 8'h01); step(); check("load_01", 64'(bus8.Q), 64'h01);
    drive8(1'b1, 2'b00, 8'h00); step(); check("dec_01", 64'(bus8.Q), 64'h00);
    drive8(1'b1, 2'b10, 8'hFE); step(); check("load_fe", 64'(bus8.Q), 64'hFE);
    drive8(1'b1, 2'b01, 8'h00); step(); check("inc_fe", 64'(bus8.Q), 64'hFF);

    // Reset priority over a pending load, then load after release
    rst_n = 1'b0;
    drive8(1'b1, 2'b10, 8'h55);
    step(); check("rst_prio", 64'(bus8.Q), 64'h00);
    rst_n = 1'b1;
    step(); check("post_rst_load", 64'(bus8.Q), 64'h55);
    drive8(1'b0, 2'b00, 8'h00);

    // Narrow instance with non-zero reset value
    rst_n = 1'b0;
    drive4(1'b1, 2'b01, 4'h0);
    step(); check("rst4_prio", 64'(bus4.Q), 64'h9);
    rst_n = 1'b1;
    step(); check("inc4_a", 64'(bus4.Q), 64'hA);
    step(); check("inc4_b", 64'(bus4.Q), 64'hB);
    drive4(1'b1, 2'b11, 4'h9); step(); check("clr4_zero", 64'(bus4.Q), 64'h0);
    drive4(1'b1, 2'b00, 4'h0); step(); check("dec4_00", 64'(bus4.Q), SAT ? 64'h0 : 64'hF);
    drive4(1'b1, 2'b10, 4'hF); step(); check("load4_f", 64'(bus4.Q), 64'hF);
    drive4(1'b1, 2'b01, 4'h0); step(); check("inc4_f", 64'(bus4.Q), SAT ? 64'hF : 64'h0);
    drive4(1'b0, 2'b10, 4'h3); step(); check("hold4", 64'(bus4.Q), SAT ? 64'hF : 64'h0);
    check("dut8_idle", 64'(bus8.Q), 64'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
